// File: rtl/tenure_arbiter_pkg.sv
// tenure_arbiter_pkg: shared types and defaults for the accumulator subsystem bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: FSM state encoding, default requester count and tenure limit,
//           and an index-width helper that stays legal for a single requester.
package tenure_arbiter_pkg;

  // Four processors share the memory bus; a tenure of 16 cycles bounds the
  // worst-case wait of any processor to a few hundred nanoseconds.
  localparam int N_REQ_DEF      = 4;
  localparam int MAX_TENURE_DEF = 16;

  // IDLE and TURNAROUND arbitrate identically; TURNAROUND exists so that the
  // mandatory dead cycle between two owners is visible as its own state.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    TURNAROUND = 2'd2
  } state_t;

  // Width of a requester index; never zero so that a one-requester build
  // still has a legal owner port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tenure_arbiter_if.sv
// tenure_arbiter_if: request/grant bundle between the processors and the bus arbiter.
// Latency: n/a (wires only).
// Backpressure: none; req is level-held by each processor until it is granted.
// Signals: req (processors -> arbiter), grant / owner / bus_busy / preempt
//          (arbiter -> processors and the memory bus).
//          master = arbiter side, slave = processor / bus side.
interface tenure_arbiter_if import tenure_arbiter_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        grant;
  logic [idx_w(N_REQ)-1:0] owner;
  logic                    bus_busy;
  logic                    preempt;

  // The arbiter owns every grant-side signal and only observes requests.
  modport master (
    input  req,
    output grant,
    output owner,
    output bus_busy,
    output preempt
  );

  // Processors drive requests and watch the grant state.
  modport slave (
    output req,
    input  grant,
    input  owner,
    input  bus_busy,
    input  preempt
  );

endinterface

// File: rtl/tenure_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search over the request vector.
// Latency: purely combinational, zero cycles.
// Backpressure: none; found=0 simply means nobody is requesting.
// Ports: req (request vector), last (most recent grantee),
//        winner (index of first set req after last, wrapping), found (any req set).
module rr_pick import tenure_arbiter_pkg::*; #(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [idx_w(N_REQ)-1:0] last,
  output logic [idx_w(N_REQ)-1:0] winner,
  output logic                    found
);

  localparam int IW = idx_w(N_REQ);

  logic [IW-1:0] cand;

  // Walk last+1, last+2, ... last+N_REQ (mod N_REQ). The final step lands on
  // last itself, so the previous owner only wins when nobody else asks.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(last) + i) % N_REQ);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tenure_arbiter.sv
// tenure_arbiter: round-robin memory-bus arbiter with a bounded tenure and forced release.
// Latency: grant one cycle after a request is sampled; each handover has one dead cycle.
// Backpressure: none; requesters hold req until granted, a waiting peer revokes at MAX_TENURE.
// Ports: clk, reset (async, active high), bus (tenure_arbiter_if.master):
//        req in; grant (registered one-hot-or-zero), owner (valid while bus_busy),
//        bus_busy (= |grant), preempt (one-cycle pulse on a timeout revocation) out.
module tenure_arbiter import tenure_arbiter_pkg::*; #(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int MAX_TENURE = MAX_TENURE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  tenure_arbiter_if.master bus
);

  localparam int IW = idx_w(N_REQ);
  // Wide enough to hold MAX_TENURE itself; the counter saturates there and
  // restarts at 1, so it never wraps through zero.
  localparam int CW = $clog2(MAX_TENURE + 1);

  localparam logic [CW-1:0]    TENURE_LIMIT = CW'(MAX_TENURE);
  localparam logic [CW-1:0]    TENURE_ONE   = CW'(1);
  localparam logic [N_REQ-1:0] GRANT_ONE    = N_REQ'(1);
  localparam logic [IW-1:0]    LAST_RESET   = IW'(N_REQ - 1);

  state_t           state;
  logic [N_REQ-1:0] grant_q;
  logic [IW-1:0]    owner_q;
  logic [IW-1:0]    last_q;
  logic [CW-1:0]    tenure_q;
  logic             busy_q;
  logic             preempt_q;

  logic [IW-1:0]    pick_idx;
  logic             pick_found;
  logic             owner_req;
  logic             others_req;
  logic             tenure_full;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req    (bus.req),
    .last   (last_q),
    .winner (pick_idx),
    .found  (pick_found)
  );

  assign owner_req   = bus.req[owner_q];
  // grant_q is the owner's one-hot in GRANT, so masking it leaves the peers.
  assign others_req  = |(bus.req & ~grant_q);
  assign tenure_full = (tenure_q == TENURE_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      last_q    <= LAST_RESET;
      tenure_q  <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      unique case (state)
        IDLE, TURNAROUND: begin
          if (pick_found) begin
            state    <= GRANT;
            grant_q  <= GRANT_ONE << pick_idx;
            owner_q  <= pick_idx;
            last_q   <= pick_idx;
            tenure_q <= TENURE_ONE;
            busy_q   <= 1'b1;
          end else begin
            state    <= IDLE;
            grant_q  <= '0;
            tenure_q <= '0;
            busy_q   <= 1'b0;
          end
        end

        GRANT: begin
          if (!owner_req) begin
            // Voluntary release wins over a coincident expiry: no preempt.
            state    <= TURNAROUND;
            grant_q  <= '0;
            tenure_q <= '0;
            busy_q   <= 1'b0;
          end else if (tenure_full) begin
            if (others_req) begin
              state     <= TURNAROUND;
              grant_q   <= '0;
              tenure_q  <= '0;
              busy_q    <= 1'b0;
              preempt_q <= 1'b1;
            end else begin
              // Nobody is waiting: keep the bus and start a fresh tenure.
              tenure_q <= TENURE_ONE;
            end
          end else begin
            tenure_q <= tenure_q + TENURE_ONE;
          end
        end

        default: begin
          state    <= IDLE;
          grant_q  <= '0;
          tenure_q <= '0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.owner    = owner_q;
  assign bus.bus_busy = busy_q;
  assign bus.preempt  = preempt_q;

  // Structural invariants of the registered outputs.
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (reset)
    $onehot0(grant_q));
  a_busy_matches  : assert property (@(posedge clk) disable iff (reset)
    busy_q == (|grant_q));
  a_preempt_idle  : assert property (@(posedge clk) disable iff (reset)
    preempt_q |-> (grant_q == '0));
  a_owner_matches : assert property (@(posedge clk) disable iff (reset)
    busy_q |-> grant_q[owner_q]);

endmodule

// File: tb/tb_tenure_arbiter.sv
// tb_tenure_arbiter: directed scenarios plus a sticky-random soak against a queue-free
// behavioural model (who holds the bus, for how long, who went last).
// Inputs change 1 time unit after each rising edge; outputs are compared on falling edges.
module tb_tenure_arbiter;
  import tenure_arbiter_pkg::*;

  localparam int N        = 4;
  localparam int MT       = 16;
  localparam int WAIT_MAX = 3 * (MT + 1);

  logic clk   = 1'b0;
  logic reset = 1'b0;

  tenure_arbiter_if #(.N_REQ(N)) bus ();

  tenure_arbiter #(
    .N_REQ      (N),
    .MAX_TENURE (MT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_holder = index holding the bus, -1 when nobody does.
  int         m_holder = -1;
  int         m_tenure = 0;
  int         m_last   = N - 1;
  int         m_pre    = 0;
  int         m_c;
  logic [N-1:0] m_r;
  logic [N-1:0] m_req_seen = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_holder   = -1;
      m_tenure   = 0;
      m_last     = N - 1;
      m_pre      = 0;
      m_req_seen = '0;
    end else begin
      m_r        = bus.req;
      m_req_seen = m_r;
      m_pre      = 0;
      if (m_holder < 0) begin
        for (int k = 1; k <= N; k++) begin
          m_c = (m_last + k) % N;
          if (m_holder < 0 && m_r[m_c]) m_holder = m_c;
        end
        if (m_holder >= 0) begin
          m_tenure = 1;
          m_last   = m_holder;
        end
      end else if (!m_r[m_holder]) begin
        m_holder = -1;
      end else if (m_tenure == MT) begin
        if ((m_r & ~(N'(1) << m_holder)) != '0) begin
          m_holder = -1;
          m_pre    = 1;
        end else begin
          m_tenure = 1;
        end
      end else begin
        m_tenure++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int exp_g;
  int worst;
  int wait_cnt [N];

  always @(negedge clk) begin
    exp_g = (m_holder < 0) ? 0 : (1 << m_holder);
    chk("model grant", int'(bus.grant), exp_g);
    chk("model bus_busy", int'(bus.bus_busy), int'(m_holder >= 0));
    chk("model preempt", int'(bus.preempt), m_pre);
    if (m_holder >= 0) chk("model owner", int'(bus.owner), m_holder);
    chk("grant one-hot-or-zero", int'($countones(bus.grant) <= 1), 1);
    chk("bus_busy vs or of grant", int'(bus.bus_busy), int'(|bus.grant));

    worst = 0;
    for (int i = 0; i < N; i++) begin
      if (reset || !m_req_seen[i] || bus.grant[i]) wait_cnt[i] = 0;
      else wait_cnt[i]++;
      if (wait_cnt[i] > worst) worst = wait_cnt[i];
    end
    checks++;
    if (worst > WAIT_MAX) begin
      errors++;
      $display("FAIL wait bound: waited %0d cycles, limit %0d", worst, WAIT_MAX);
    end
  end

  // ---------------- stimulus ----------------
  int s2_exp [1:16] = '{1, 1, 1, 0, 2, 2, 2, 0, 4, 4, 4, 0, 8, 8, 8, 0};
  logic [N-1:0] rnd_req;

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    adv();
    adv();
    reset   = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req = '0;
    #1 reset = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("reset grant", int'(bus.grant), 0);
    chk("reset owner", int'(bus.owner), 0);
    chk("reset bus_busy", int'(bus.bus_busy), 0);
    chk("reset preempt", int'(bus.preempt), 0);
    adv();
    reset = 1'b0;

    // Scenario 1: single request, latency 1.
    bus.req = 4'b0001;
    adv();
    chk("s1 grant", int'(bus.grant), 1);
    chk("s1 owner", int'(bus.owner), 0);
    chk("s1 bus_busy", int'(bus.bus_busy), 1);
    chk("s1 model holder", m_holder, 0);
    bus.req = '0;
    adv();
    chk("s1 release grant", int'(bus.grant), 0);
    adv();

    // Scenario 2: all request, each owner releases after 3 grant cycles.
    do_reset();
    bus.req = 4'b1111;
    for (int c = 1; c <= 16; c++) begin
      adv();
      chk($sformatf("s2 grant c%0d", c), int'(bus.grant), s2_exp[c]);
      if (c == 3)  bus.req = 4'b1110;
      if (c == 7)  bus.req = 4'b1100;
      if (c == 11) bus.req = 4'b1000;
      if (c == 15) bus.req = 4'b0000;
    end
    adv();

    // Scenario 3: req[0] held, req[2] arrives at cycle 5, tenure expiry.
    do_reset();
    bus.req = 4'b0001;
    for (int c = 1; c <= 18; c++) begin
      adv();
      chk($sformatf("s3 grant c%0d", c), int'(bus.grant),
          (c <= 16) ? 1 : ((c == 17) ? 0 : 4));
      chk($sformatf("s3 preempt c%0d", c), int'(bus.preempt), int'(c == 17));
      if (c == 17) chk("s3 model preempt", m_pre, 1);
      if (c == 18) chk("s3 model holder", m_holder, 2);
      if (c == 5) bus.req = 4'b0101;
    end
    repeat (22) adv();
    bus.req = '0;
    adv();
    adv();

    // Scenario 4: lone requester keeps the bus across tenure restarts.
    do_reset();
    bus.req = 4'b0010;
    for (int c = 1; c <= 40; c++) begin
      adv();
      chk($sformatf("s4 grant c%0d", c), int'(bus.grant), 2);
      chk($sformatf("s4 preempt c%0d", c), int'(bus.preempt), 0);
    end
    chk("s4 model holder", m_holder, 1);
    bus.req = '0;
    adv();
    adv();

    // Scenario 5: reset during requester 3's tenure.
    do_reset();
    bus.req = 4'b1000;
    repeat (5) adv();
    chk("s5 pre-reset grant", int'(bus.grant), 8);
    reset   = 1'b1;
    bus.req = 4'b1010;
    #1;
    chk("s5 async grant", int'(bus.grant), 0);
    chk("s5 async bus_busy", int'(bus.bus_busy), 0);
    adv();
    chk("s5 held grant", int'(bus.grant), 0);
    adv();
    reset = 1'b0;
    adv();
    chk("s5 first grant", int'(bus.grant), 2);
    chk("s5 first owner", int'(bus.owner), 1);
    chk("s5 model holder", m_holder, 1);
    bus.req = '0;
    adv();
    adv();

    // Scenario 6: sticky random requests.
    do_reset();
    rnd_req = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 15) == 0) rnd_req[i] = ~rnd_req[i];
      end
      bus.req = rnd_req;
      adv();
    end
    bus.req = '0;
    repeat (3) adv();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
